// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth multiplier sequencer
package booth_pkg;

    localparam int BOOTH_N_DEFAULT = 16;
    localparam int WDOG_MARGIN     = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_LOAD_M = 3'd3,
        ST_LOAD_Q = 3'd4,
        ST_WAIT   = 3'd5,
        ST_OUT    = 3'd6
    } seq_state_t;

endpackage

// File: rtl/booth_operand_fifo.sv
// rtl/booth_operand_fifo.sv - operand-pair FIFO feeding the Booth sequencer
// Ports: clk, rst (sync active-high); push/din write side; pop/dout read side
// (dout is the current head); full, empty, count status.
module booth_operand_fifo
    import booth_pkg::*;
#(
    parameter int WIDTH = 2 * BOOTH_N_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// rtl/booth_mul_sequencer.sv - operand front-end and result back-end for the Booth core
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_mcand/in_mplier operand
// input; core_clr/core_start/core_data_in/core_done/core_product core interface;
// out_valid/out_ready/out_product/out_error result output; busy status.
module booth_mul_sequencer
    import booth_pkg::*;
#(
    parameter int N           = BOOTH_N_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int WDOG_CYCLES = 4 * N + WDOG_MARGIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_mcand,
    input  logic [N-1:0]     in_mplier,
    output logic             core_clr,
    output logic             core_start,
    output logic [N-1:0]     core_data_in,
    input  logic             core_done,
    input  logic [2*N-1:0]   core_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_product,
    output logic             out_error,
    output logic             busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    seq_state_t       state;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [2*N-1:0]   fifo_dout;
    logic             fifo_pop;
    logic [N-1:0]     mplier_q;
    logic [WW-1:0]    wdog_cnt;
    logic             post_rst;

    assign in_ready = !fifo_full;
    assign fifo_pop = (state == ST_ISSUE);
    assign busy     = (state != ST_IDLE) || (fifo_count != '0);

    booth_operand_fifo #(
        .WIDTH (2 * N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .din   ({in_mcand, in_mplier}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            core_clr     <= 1'b0;
            core_start   <= 1'b0;
            core_data_in <= '0;
            out_valid    <= 1'b0;
            out_product  <= '0;
            out_error    <= 1'b0;
            mplier_q     <= '0;
            wdog_cnt     <= '0;
            post_rst     <= 1'b1;
        end else begin
            // The core's state is unknown coming out of reset, so it gets one
            // clear pulse even before any operand arrives.
            post_rst   <= 1'b0;
            core_clr   <= post_rst;
            core_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state        <= ST_CLR;
                        core_clr     <= 1'b1;
                        core_data_in <= '0;
                    end
                end
                ST_CLR: begin
                    state      <= ST_ISSUE;
                    core_start <= 1'b1;
                end
                ST_ISSUE: begin
                    // Head is popped this cycle; mcand rides the bus register
                    // directly, mplier is kept for the following cycle.
                    core_data_in <= fifo_dout[2*N-1:N];
                    mplier_q     <= fifo_dout[N-1:0];
                    state        <= ST_LOAD_M;
                end
                ST_LOAD_M: begin
                    core_data_in <= mplier_q;
                    state        <= ST_LOAD_Q;
                end
                ST_LOAD_Q: begin
                    wdog_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wdog_cnt <= wdog_cnt + WW'(1);
                    // done is checked first so a result landing on the last
                    // watchdog cycle is still delivered.
                    if (core_done) begin
                        out_product <= core_product;
                        out_error   <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= ST_OUT;
                    end else if (wdog_cnt == WDOG_LAST) begin
                        out_product <= '0;
                        out_error   <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!fifo_empty) begin
                            state        <= ST_CLR;
                            core_clr     <= 1'b1;
                            core_data_in <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
